spm_sequencer: RTL

Front-end sequencer for the three-neuron SPM datapath. It accepts the network's parameter words serially over a valid/ready stream and assembles them into a parallel bank. It then drives the SPM inputs stably for the SPM's fixed compute latency, captures `o_final_result`, and returns that result on a valid/ready output stream. The SPM is a passive fixed-latency responder; this block is the initiator that feeds it and collects its answer.

---
 rtl/spm_pkg.sv | 10 +
 rtl/spm_seq_word_bank.sv | 46 ++++
 rtl/spm_sequencer.sv | 79 +++++++
 3 files changed

// File: rtl/spm_pkg.sv
// spm_pkg: shared state encoding, slot offsets and constants for the SPM sequencer
package spm_pkg;
    typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_OUT} state_t;
    localparam int SLOT_A1 = 0;
    localparam int SLOT_W1 = 1;
    localparam int SLOT_B1 = 2;
    localparam int SLOT_W2 = 3;
    localparam logic [7:0] FP_EXP_ALL1 = 8'hFF;
    localparam int SPM_LATENCY_DEF = 24;
endpackage

// File: rtl/spm_seq_word_bank.sv
// spm_seq_word_bank: shadow parameter file, atomically committed to the flattened SPM inputs
module spm_seq_word_bank
    import spm_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int N_NEURONS = 3,
    localparam int NW       = 4 * N_NEURONS,
    localparam int IDX_W    = $clog2(NW)
) (
    input  logic                        clk,
    input  logic                        areset,
    input  logic                        we,
    input  logic [IDX_W-1:0]            widx,
    input  logic [DATA_W-1:0]           wdata,
    input  logic                        commit,
    output logic [N_NEURONS*DATA_W-1:0] o_a1,
    output logic [N_NEURONS*DATA_W-1:0] o_w1,
    output logic [N_NEURONS*DATA_W-1:0] o_b1,
    output logic [N_NEURONS*DATA_W-1:0] o_w2
);
    logic [DATA_W-1:0] shadow [NW];
    logic [DATA_W-1:0] nxt    [NW];
    // The word written on the commit edge must be visible in the same commit
    for (genvar k = 0; k < NW; k++) begin : g_nxt
        assign nxt[k] = (we && widx == IDX_W'(k)) ? wdata : shadow[k];
    end
    always_ff @(posedge clk) begin
        if (areset) begin
            for (int i = 0; i < NW; i++) shadow[i] <= '0;
            o_a1 <= '0;
            o_w1 <= '0;
            o_b1 <= '0;
            o_w2 <= '0;
        end else begin
            if (we) shadow[widx] <= wdata;
            if (commit) begin
                for (int n = 0; n < N_NEURONS; n++) begin
                    o_a1[n*DATA_W +: DATA_W] <= nxt[4*n+SLOT_A1];
                    o_w1[n*DATA_W +: DATA_W] <= nxt[4*n+SLOT_W1];
                    o_b1[n*DATA_W +: DATA_W] <= nxt[4*n+SLOT_B1];
                    o_w2[n*DATA_W +: DATA_W] <= nxt[4*n+SLOT_W2];
                end
            end
        end
    end
endmodule

// File: rtl/spm_sequencer.sv
// spm_sequencer: serial parameter loader, fixed-latency SPM wait and result stream
// Optional NaN flag on the result is enabled by defining SPM_SEQ_NAN_CHECK_EN.
module spm_sequencer
    import spm_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int N_NEURONS = 3,
    parameter int LATENCY   = SPM_LATENCY_DEF
) (
    input  logic                        clk,
    input  logic                        areset,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_W-1:0]           s_data,
    output logic [N_NEURONS*DATA_W-1:0] o_a1,
    output logic [N_NEURONS*DATA_W-1:0] o_w1,
    output logic [N_NEURONS*DATA_W-1:0] o_b1,
    output logic [N_NEURONS*DATA_W-1:0] o_w2,
    input  logic [DATA_W-1:0]           i_spm_result,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_W-1:0]           m_data,
    output logic                        m_err,
    output logic                        busy
);
    localparam int NW    = 4 * N_NEURONS;
    localparam int IDX_W = $clog2(NW);
    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [7:0]       cnt;
    logic             accept, commit, cap;
    assign s_ready = (state == ST_LOAD) && !areset;
    assign accept  = s_valid && s_ready;
    assign commit  = accept && (idx == IDX_W'(NW - 1));
    assign cap     = (state == ST_WAIT) && (cnt == 8'(LATENCY - 1));
    assign m_valid = (state == ST_OUT);
    assign busy    = (state != ST_LOAD);
    always_comb begin
        state_nxt = state;
        if (commit) state_nxt = ST_WAIT;
        if (cap) state_nxt = ST_OUT;
        if (m_valid && m_ready) state_nxt = ST_LOAD;
    end
    always_ff @(posedge clk) begin
        if (areset) begin
            state  <= ST_LOAD;
            idx    <= '0;
            cnt    <= '0;
            m_data <= '0;
        end else begin
            state <= state_nxt;
            if (accept) idx <= commit ? '0 : idx + 1'b1;
            if (state == ST_WAIT) cnt <= cap ? 8'd0 : cnt + 8'd1;
            if (cap) m_data <= i_spm_result;
        end
    end
`ifdef SPM_SEQ_NAN_CHECK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (areset) err_q <= 1'b0;
        else if (cap) err_q <= (i_spm_result[30:23] == FP_EXP_ALL1) && (|i_spm_result[22:0]);
    end
    assign m_err = err_q;
`else
    assign m_err = 1'b0;
`endif
    spm_seq_word_bank #(.DATA_W(DATA_W), .N_NEURONS(N_NEURONS)) u_bank (
        .clk    (clk),
        .areset (areset),
        .we     (accept),
        .widx   (idx),
        .wdata  (s_data),
        .commit (commit),
        .o_a1   (o_a1),
        .o_w1   (o_w1),
        .o_b1   (o_b1),
        .o_w2   (o_w2)
    );
endmodule
